i2c_arbiter: RTL and testbench
==============================

# i2c_arbiter

Shares one `I2C_Comm` engine between `NUM_REQ` on-chip requesters, for example ADC configuration and sensor polling. Arbitration is round-robin. The block presents each winning request to the engine as a one-cycle `load` and waits for the engine's `busy` to fall. It returns read data and completion status to the requester, and a watchdog stops a stuck transfer from locking out the bus. It sits between requester logic and the `I2C_Comm` instance; the top level builds the tri-state `data` bus from `i2c_wr_data` and `i2c_data_oe`.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, 65535: watchdog limit in `clk` cycles, counted from `load` to completion.
- `clk`  in  1: system clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  NUM_REQ: request pending; held until `req_ready` for that index.
- `req_addr`  in  7*NUM_REQ: 7-bit slave address per requester, packed, index 0 in the LSBs.
- `req_num_bytes`  in  NUM_REQ: 0 = 1 byte, 1 = 2 bytes.
- `req_rd_wr`  in  NUM_REQ: 1 = read, 0 = write.
- `req_wr_data`  in  16*NUM_REQ: write payload, packed.
- `req_ready`  out  NUM_REQ: one-cycle accept pulse; one-hot.
- `rsp_valid`  out  NUM_REQ: one-cycle completion pulse; one-hot.
- `rsp_data`  out  16: read data, valid with `rsp_valid`; 0 for writes and timeouts.
- `rsp_timeout`  out  1: completion was a watchdog expiry; valid with `rsp_valid`.
- `arb_busy`  out  1: high in every state except IDLE.
- `i2c_load`, `i2c_addr[6:0]`, `i2c_num_bytes`, `i2c_rd_wr`  out: drive `I2C_Comm` `load`/`addr`/`numBytes`/`rd_wr`.
- `i2c_wr_data`  out  16; `i2c_data_oe`  out  1: write payload and its bus enable.
- `i2c_rd_data`  in  16: the `data` bus as seen by the fabric.
- `i2c_busy`, `i2c_data_ready`  in  1: engine `busy` and `dataReady`.

## Operation
- States: IDLE, LOAD, WAIT_START, WAIT_DONE, RESP.
- **IDLE**
  - Arbitrates only when `i2c_busy`=0 and some `req_valid` is high.
  - The winner is the first requester with `req_valid` set, searching from `ptr` upward and wrapping.
  - Latches the winner's addr, num_bytes, rd_wr and wr_data into the `i2c_*` registers and records the winner index w.
  - Next state: LOAD.
- **LOAD**, exactly 1 cycle:
  - `i2c_load`=1, `i2c_data_oe`=1, `req_ready[w]`=1.
  - Clears the watchdog counter and the read-data register.
  - Next state: WAIT_START.
- **WAIT_START**: leaves on `i2c_busy`=1 to WAIT_DONE.
- **WAIT_DONE**
  - Any cycle with `i2c_rd_wr`=1 and `i2c_data_ready`=1 latches `i2c_rd_data`; the last capture wins.
  - `i2c_busy`=0 moves to RESP.
- **Watchdog**
  - Counts every cycle spent in WAIT_START and WAIT_DONE.
  - On reaching `TIMEOUT_CYCLES` it forces RESP with the timeout flag set; this has priority over a same-cycle `i2c_busy` edge.
- **RESP**, 1 cycle:
  - `rsp_valid[w]`=1.
  - `rsp_data` = captured data for a read; 0 for a write or a timeout.
  - `rsp_timeout` = timeout flag.
  - `ptr` ← (w+1) mod `NUM_REQ`.
  - Next state: IDLE.
- `i2c_addr`, `i2c_num_bytes`, `i2c_rd_wr` and `i2c_wr_data` hold their values from LOAD until the next grant.
- The engine cannot be aborted. After a timeout, IDLE waits for `i2c_busy`=0 before granting again.

## Timing
- Reset values:
  - state = IDLE, `ptr` = 0, counter = 0.
  - Every output is 0: `i2c_*` registers, `i2c_data_oe`, `req_ready`, `rsp_valid`, `rsp_data`, `rsp_timeout`, `arb_busy`.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Request held at edge N in IDLE gives `i2c_load` and `req_ready` at cycle N+1.
- `rsp_valid` comes one cycle after the edge that samples `i2c_busy`=0 in WAIT_DONE.
- Back-to-back: the earliest next `i2c_load` is 2 cycles after `rsp_valid` (RESP→IDLE→LOAD).
- Simultaneous requests are granted in round-robin order. A requester that re-asserts immediately loses to any other pending requester.
- Reset mid-transfer: return to IDLE with all outputs cleared and no `rsp_valid` for the aborted transfer. The first grant after reset waits for `i2c_busy`=0.
- Dropping `req_valid` before `req_ready` is a protocol violation; its behaviour is not defined.

## Structure
- Package `i2c_pkg` holds:
  - state encoding;
  - `I2C_ADDR_W`=7, `I2C_DATA_W`=16;
  - `I2C_RD`=1, `I2C_WR`=0.
- Sub-module `rr_arbiter`: combinational round-robin picker. Inputs are `req_valid` and `ptr`; outputs are one-hot `grant` and its index.

## Test plan
- **Single write**: req0 write, addr 0x55, data 0xAAAA, 2 bytes.
  - `i2c_load` and `req_ready[0]` are high 1 cycle later, with `i2c_addr`=0x55 and `i2c_data_oe`=1.
  - Engine model holds busy for 40 cycles; then `rsp_valid[0]`=1, `rsp_data`=0, `rsp_timeout`=0.
- **Read**: req2 read, 1 byte; model pulses `i2c_data_ready` with `i2c_rd_data`=0x00C3.
  - `rsp_valid[2]`=1 with `rsp_data`=0x00C3.
- **Round-robin**: all 4 requesters assert together after reset.
  - Grant order is 0,1,2,3; then req0 and req3 re-assert and are granted 0 then 3 (`ptr` wrapped).
- **Timeout**: `TIMEOUT_CYCLES`=100, model never raises busy.
  - `rsp_valid` with `rsp_timeout`=1 exactly 100 cycles after entering WAIT_START.
  - With `i2c_busy` then held high, no new `i2c_load` is issued.
- **Reset mid-transfer**: `rst` pulses during WAIT_DONE.
  - All outputs are 0 the next cycle and no `rsp_valid` is produced.
  - A pending req1 is granted only after `i2c_busy` falls.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C requester arbiter.
package i2c_pkg;

   localparam int I2C_ADDR_W = 7;
   localparam int I2C_DATA_W = 16;

   // Direction encoding on the engine's rd_wr input
   localparam logic I2C_RD = 1'b1;
   localparam logic I2C_WR = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WAIT_START,
      ST_WAIT_DONE,
      ST_RESP
   } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [PTR_W-1:0]   grant_idx
);

   // Candidate index for each search offset, i.e. (ptr + offset) mod NUM_REQ.
   // ptr and offset are both below NUM_REQ, so one conditional subtract wraps it.
   logic [PTR_W:0]   sum  [NUM_REQ];
   logic [PTR_W-1:0] cand [NUM_REQ];
   logic             found;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
         assign sum[gi]  = {1'b0, ptr} + (PTR_W+1)'(gi);
         assign cand[gi] = (sum[gi] >= (PTR_W+1)'(NUM_REQ))
                         ? PTR_W'(sum[gi] - (PTR_W+1)'(NUM_REQ))
                         : sum[gi][PTR_W-1:0];
      end
   endgenerate

   // Walk offsets in priority order and keep the first hit
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req_valid[cand[i]]) begin
            found     = 1'b1;
            grant_idx = cand[i];
         end
      end
      if (found) begin
         grant[grant_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin sharing of one I2C_Comm engine between NUM_REQ requesters,
// with a watchdog so a stuck transfer cannot hold the arbiter forever.
module i2c_arbiter
   import i2c_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [7*NUM_REQ-1:0]       req_addr,
   input  logic [NUM_REQ-1:0]         req_num_bytes,
   input  logic [NUM_REQ-1:0]         req_rd_wr,
   input  logic [16*NUM_REQ-1:0]      req_wr_data,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic [NUM_REQ-1:0]         rsp_valid,
   output logic [15:0]                rsp_data,
   output logic                       rsp_timeout,
   output logic                       arb_busy,
   output logic                       i2c_load,
   output logic [6:0]                 i2c_addr,
   output logic                       i2c_num_bytes,
   output logic                       i2c_rd_wr,
   output logic [15:0]                i2c_wr_data,
   output logic                       i2c_data_oe,
   input  logic [15:0]                i2c_rd_data,
   input  logic                       i2c_busy,
   input  logic                       i2c_data_ready
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   // Per-requester views of the packed address and payload buses
   logic [I2C_ADDR_W-1:0] addr_arr [NUM_REQ];
   logic [I2C_DATA_W-1:0] wd_arr   [NUM_REQ];

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign addr_arr[gi] = req_addr[gi*I2C_ADDR_W +: I2C_ADDR_W];
         assign wd_arr[gi]   = req_wr_data[gi*I2C_DATA_W +: I2C_DATA_W];
      end
   endgenerate

   arb_state_t            state_reg, state_next;
   logic [PTR_W-1:0]      ptr_reg, ptr_next;
   logic [PTR_W-1:0]      w_reg, w_next;
   logic [CNT_W-1:0]      cnt_reg, cnt_next;
   logic [I2C_DATA_W-1:0] rd_data_reg, rd_data_next;

   logic                  i2c_load_reg, i2c_load_next;
   logic [I2C_ADDR_W-1:0] i2c_addr_reg, i2c_addr_next;
   logic                  i2c_num_bytes_reg, i2c_num_bytes_next;
   logic                  i2c_rd_wr_reg, i2c_rd_wr_next;
   logic [I2C_DATA_W-1:0] i2c_wr_data_reg, i2c_wr_data_next;
   logic                  i2c_data_oe_reg, i2c_data_oe_next;
   logic [NUM_REQ-1:0]    req_ready_reg, req_ready_next;
   logic [NUM_REQ-1:0]    rsp_valid_reg, rsp_valid_next;
   logic [I2C_DATA_W-1:0] rsp_data_reg, rsp_data_next;
   logic                  rsp_timeout_reg, rsp_timeout_next;
   logic                  arb_busy_reg, arb_busy_next;

   logic [NUM_REQ-1:0]    grant;
   logic [PTR_W-1:0]      grant_idx;
   logic                  wd_expired;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr (
      .req_valid (req_valid),
      .ptr       (ptr_reg),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // The cycle in which the counter would reach the limit is the expiry cycle,
   // so RESP lands exactly TIMEOUT_CYCLES cycles after WAIT_START is entered.
   assign wd_expired = (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

   // Next-state and next-output decode; outputs are registered from these
   always_comb begin
      state_next         = state_reg;
      ptr_next           = ptr_reg;
      w_next             = w_reg;
      cnt_next           = cnt_reg;
      rd_data_next       = rd_data_reg;
      i2c_load_next      = 1'b0;
      i2c_addr_next      = i2c_addr_reg;
      i2c_num_bytes_next = i2c_num_bytes_reg;
      i2c_rd_wr_next     = i2c_rd_wr_reg;
      i2c_wr_data_next   = i2c_wr_data_reg;
      i2c_data_oe_next   = 1'b0;
      req_ready_next     = '0;
      rsp_valid_next     = '0;
      rsp_data_next      = '0;
      rsp_timeout_next   = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            // The engine cannot be aborted, so never grant while it is still busy
            if (!i2c_busy && (|req_valid)) begin
               state_next         = ST_LOAD;
               w_next             = grant_idx;
               i2c_addr_next      = addr_arr[grant_idx];
               i2c_num_bytes_next = req_num_bytes[grant_idx];
               i2c_rd_wr_next     = req_rd_wr[grant_idx];
               i2c_wr_data_next   = wd_arr[grant_idx];
               i2c_load_next      = 1'b1;
               i2c_data_oe_next   = 1'b1;
               req_ready_next     = grant;
            end
         end

         ST_LOAD: begin
            cnt_next     = '0;
            rd_data_next = '0;
            state_next   = ST_WAIT_START;
         end

         ST_WAIT_START: begin
            cnt_next = cnt_reg + CNT_W'(1);
            if (wd_expired) begin
               state_next             = ST_RESP;
               rsp_valid_next[w_reg]  = 1'b1;
               rsp_timeout_next       = 1'b1;
            end else if (i2c_busy) begin
               state_next = ST_WAIT_DONE;
            end
         end

         ST_WAIT_DONE: begin
            cnt_next = cnt_reg + CNT_W'(1);
            if ((i2c_rd_wr_reg == I2C_RD) && i2c_data_ready) begin
               rd_data_next = i2c_rd_data;
            end
            if (wd_expired) begin
               state_next             = ST_RESP;
               rsp_valid_next[w_reg]  = 1'b1;
               rsp_timeout_next       = 1'b1;
            end else if (!i2c_busy) begin
               state_next             = ST_RESP;
               rsp_valid_next[w_reg]  = 1'b1;
               rsp_data_next          = (i2c_rd_wr_reg == I2C_RD) ? rd_data_next : '0;
            end
         end

         ST_RESP: begin
            ptr_next   = (w_reg == PTR_W'(NUM_REQ - 1)) ? '0 : w_reg + PTR_W'(1);
            state_next = ST_IDLE;
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign arb_busy_next = (state_next != ST_IDLE);

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg         <= ST_IDLE;
         ptr_reg           <= '0;
         w_reg             <= '0;
         cnt_reg           <= '0;
         rd_data_reg       <= '0;
         i2c_load_reg      <= 1'b0;
         i2c_addr_reg      <= '0;
         i2c_num_bytes_reg <= 1'b0;
         i2c_rd_wr_reg     <= 1'b0;
         i2c_wr_data_reg   <= '0;
         i2c_data_oe_reg   <= 1'b0;
         req_ready_reg     <= '0;
         rsp_valid_reg     <= '0;
         rsp_data_reg      <= '0;
         rsp_timeout_reg   <= 1'b0;
         arb_busy_reg      <= 1'b0;
      end else begin
         state_reg         <= state_next;
         ptr_reg           <= ptr_next;
         w_reg             <= w_next;
         cnt_reg           <= cnt_next;
         rd_data_reg       <= rd_data_next;
         i2c_load_reg      <= i2c_load_next;
         i2c_addr_reg      <= i2c_addr_next;
         i2c_num_bytes_reg <= i2c_num_bytes_next;
         i2c_rd_wr_reg     <= i2c_rd_wr_next;
         i2c_wr_data_reg   <= i2c_wr_data_next;
         i2c_data_oe_reg   <= i2c_data_oe_next;
         req_ready_reg     <= req_ready_next;
         rsp_valid_reg     <= rsp_valid_next;
         rsp_data_reg      <= rsp_data_next;
         rsp_timeout_reg   <= rsp_timeout_next;
         arb_busy_reg      <= arb_busy_next;
      end
   end

   assign req_ready     = req_ready_reg;
   assign rsp_valid     = rsp_valid_reg;
   assign rsp_data      = rsp_data_reg;
   assign rsp_timeout   = rsp_timeout_reg;
   assign arb_busy      = arb_busy_reg;
   assign i2c_load      = i2c_load_reg;
   assign i2c_addr      = i2c_addr_reg;
   assign i2c_num_bytes = i2c_num_bytes_reg;
   assign i2c_rd_wr     = i2c_rd_wr_reg;
   assign i2c_wr_data   = i2c_wr_data_reg;
   assign i2c_data_oe   = i2c_data_oe_reg;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed self-checking bench for i2c_arbiter with a scripted engine model.
module tb_i2c_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [27:0] req_addr;
   logic [3:0]  req_num_bytes;
   logic [3:0]  req_rd_wr;
   logic [63:0] req_wr_data;
   logic [3:0]  req_ready;
   logic [3:0]  rsp_valid;
   logic [15:0] rsp_data;
   logic        rsp_timeout;
   logic        arb_busy;
   logic        i2c_load;
   logic [6:0]  i2c_addr;
   logic        i2c_num_bytes;
   logic        i2c_rd_wr;
   logic [15:0] i2c_wr_data;
   logic        i2c_data_oe;
   logic [15:0] i2c_rd_data;
   logic        i2c_busy;
   logic        i2c_data_ready;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [52:0] all_out;
   assign all_out = {i2c_load, i2c_addr, i2c_num_bytes, i2c_rd_wr, i2c_wr_data,
                     i2c_data_oe, req_ready, rsp_valid, rsp_data, rsp_timeout, arb_busy};

   i2c_arbiter #(
      .NUM_REQ        (4),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_addr       (req_addr),
      .req_num_bytes  (req_num_bytes),
      .req_rd_wr      (req_rd_wr),
      .req_wr_data    (req_wr_data),
      .req_ready      (req_ready),
      .rsp_valid      (rsp_valid),
      .rsp_data       (rsp_data),
      .rsp_timeout    (rsp_timeout),
      .arb_busy       (arb_busy),
      .i2c_load       (i2c_load),
      .i2c_addr       (i2c_addr),
      .i2c_num_bytes  (i2c_num_bytes),
      .i2c_rd_wr      (i2c_rd_wr),
      .i2c_wr_data    (i2c_wr_data),
      .i2c_data_oe    (i2c_data_oe),
      .i2c_rd_data    (i2c_rd_data),
      .i2c_busy       (i2c_busy),
      .i2c_data_ready (i2c_data_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Absolute time limit so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "[TB] global timeout");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int idx, input logic [6:0] addr, input logic nb,
                          input logic rd, input logic [15:0] wd);
      req_addr[idx*7 +: 7]      = addr;
      req_num_bytes[idx]        = nb;
      req_rd_wr[idx]            = rd;
      req_wr_data[idx*16 +: 16] = wd;
      req_valid[idx]            = 1'b1;
   endtask

   // Wait for the grant, check it, then play the engine for busy_len cycles.
   // A dataReady pulse is always issued; only reads should return it.
   task automatic serve(input int idx, input int busy_len, input logic rd,
                        input logic [15:0] rdata, input logic [6:0] exp_addr,
                        output int lat);
      logic [15:0] exp_data;
      int n;
      exp_data = rd ? rdata : 16'h0000;
      n = 0;
      while (!i2c_load && n < 200) begin
         tick();
         n++;
      end
      lat = n;
      check_eq("load_seen", 64'(i2c_load), 64'(1));
      check_eq("req_ready", 64'(req_ready), 64'(1) << idx);
      check_eq("i2c_addr", 64'(i2c_addr), 64'(exp_addr));
      check_eq("i2c_rd_wr", 64'(i2c_rd_wr), 64'(rd));
      check_eq("data_oe", 64'(i2c_data_oe), 64'(1));
      req_valid[idx] = 1'b0;
      i2c_busy = 1'b1;
      repeat (busy_len - 1) tick();
      i2c_data_ready = 1'b1;
      i2c_rd_data    = rdata;
      tick();
      i2c_data_ready = 1'b0;
      i2c_rd_data    = 16'h0000;
      i2c_busy       = 1'b0;
      tick();
      check_eq("rsp_valid", 64'(rsp_valid), 64'(1) << idx);
      check_eq("rsp_data", 64'(rsp_data), 64'(exp_data));
      check_eq("rsp_timeout", 64'(rsp_timeout), 64'(0));
      $display("[TB] xfer req%0d addr=0x%02h rd=%0d data=0x%04h timeout=%0d lat=%0d",
               idx, i2c_addr, rd, rsp_data, rsp_timeout, lat);
   endtask

   initial begin
      int lat;
      int n;
      logic saw;

      rst            = 1'b1;
      req_valid      = '0;
      req_addr       = '0;
      req_num_bytes  = '0;
      req_rd_wr      = '0;
      req_wr_data    = '0;
      i2c_rd_data    = '0;
      i2c_busy       = 1'b0;
      i2c_data_ready = 1'b0;

      // Reset state
      repeat (3) tick();
      check_eq("reset_outputs", 64'(all_out), 64'(0));
      rst = 1'b0;
      tick();
      check_eq("idle_outputs", 64'(all_out), 64'(0));

      // Single write, 2 bytes, 40 busy cycles; dataReady must not leak into rsp_data
      set_req(0, 7'h55, 1'b1, 1'b0, 16'hAAAA);
      serve(0, 40, 1'b0, 16'hDEAD, 7'h55, lat);
      check_eq("write_lat", 64'(lat), 64'(1));
      check_eq("hold_wr_data", 64'(i2c_wr_data), 64'(16'hAAAA));
      check_eq("hold_num_bytes", 64'(i2c_num_bytes), 64'(1));
      check_eq("resp_arb_busy", 64'(arb_busy), 64'(1));
      tick();
      check_eq("rsp_one_cycle", 64'(rsp_valid), 64'(0));
      check_eq("back_idle", 64'(arb_busy), 64'(0));

      // Single read, 1 byte
      set_req(2, 7'h48, 1'b0, 1'b1, 16'h0000);
      serve(2, 12, 1'b1, 16'h00C3, 7'h48, lat);
      check_eq("read_nb", 64'(i2c_num_bytes), 64'(0));

      // Timeout: engine never raises busy
      set_req(1, 7'h2A, 1'b0, 1'b1, 16'h0000);
      n = 0;
      while (!i2c_load && n < 50) begin
         tick();
         n++;
      end
      check_eq("to_load", 64'(i2c_load), 64'(1));
      check_eq("to_ready", 64'(req_ready), 64'(4'b0010));
      req_valid[1] = 1'b0;
      tick();
      n = 0;
      while (rsp_valid == 4'b0000 && n < 200) begin
         tick();
         n++;
      end
      check_eq("to_latency", 64'(n), 64'(100));
      check_eq("to_rsp_valid", 64'(rsp_valid), 64'(4'b0010));
      check_eq("to_flag", 64'(rsp_timeout), 64'(1));
      check_eq("to_data", 64'(rsp_data), 64'(0));
      $display("[TB] xfer req1 addr=0x2a rd=1 data=0x%04h timeout=%0d", rsp_data, rsp_timeout);

      // Engine now busy and stuck: a pending request must wait
      i2c_busy = 1'b1;
      set_req(3, 7'h33, 1'b0, 1'b0, 16'h5A5A);
      saw = 1'b0;
      repeat (30) begin
         tick();
         if (i2c_load) saw = 1'b1;
      end
      check_eq("no_load_while_busy", 64'(saw), 64'(0));
      check_eq("idle_while_busy", 64'(arb_busy), 64'(0));
      i2c_busy = 1'b0;
      serve(3, 10, 1'b0, 16'h0000, 7'h33, lat);
      check_eq("grant_after_busy", 64'(lat), 64'(1));
      tick();

      // Reset in WAIT_DONE with the engine still busy
      set_req(0, 7'h11, 1'b1, 1'b0, 16'hBEEF);
      n = 0;
      while (!i2c_load && n < 50) begin
         tick();
         n++;
      end
      check_eq("rm_load", 64'(i2c_load), 64'(1));
      req_valid[0] = 1'b0;
      i2c_busy = 1'b1;
      repeat (5) tick();
      set_req(1, 7'h22, 1'b0, 1'b0, 16'h1357);
      rst = 1'b1;
      tick();
      check_eq("rm_outputs", 64'(all_out), 64'(0));
      rst = 1'b0;
      saw = 1'b0;
      repeat (10) begin
         tick();
         if (i2c_load || (rsp_valid != 4'b0000)) saw = 1'b1;
      end
      check_eq("rm_quiet", 64'(saw), 64'(0));
      i2c_busy = 1'b0;
      serve(1, 10, 1'b0, 16'h0000, 7'h22, lat);
      check_eq("rm_grant_lat", 64'(lat), 64'(1));
      tick();

      // Round-robin from a fresh reset: 0,1,2,3 then 0,3
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      set_req(0, 7'h10, 1'b0, 1'b0, 16'h0001);
      set_req(1, 7'h11, 1'b0, 1'b0, 16'h0002);
      set_req(2, 7'h12, 1'b0, 1'b0, 16'h0003);
      set_req(3, 7'h13, 1'b0, 1'b0, 16'h0004);
      serve(0, 10, 1'b0, 16'h0000, 7'h10, lat);
      serve(1, 10, 1'b0, 16'h0000, 7'h11, lat);
      check_eq("b2b_lat", 64'(lat), 64'(2));
      serve(2, 10, 1'b0, 16'h0000, 7'h12, lat);
      serve(3, 10, 1'b0, 16'h0000, 7'h13, lat);
      set_req(0, 7'h20, 1'b0, 1'b0, 16'h0005);
      set_req(3, 7'h23, 1'b0, 1'b0, 16'h0006);
      serve(0, 10, 1'b0, 16'h0000, 7'h20, lat);
      check_eq("wrap_lat", 64'(lat), 64'(2));
      serve(3, 10, 1'b0, 16'h0000, 7'h23, lat);
      tick();
      check_eq("final_idle", 64'(arb_busy), 64'(0));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
